// File: rtl/approx_err_pkg.sv
// Shared state encoding and width helpers for the approximate-multiplier error monitor.
package approx_err_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HOLD} state_t;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    function automatic int sum_w(input int width, input int log2_samples);
        return 2 * width + log2_samples;
    endfunction

    function automatic int cnt_w(input int log2_samples);
        return log2_samples + 1;
    endfunction

    function automatic int sq_w(input int width, input int log2_samples);
        return 4 * width + log2_samples;
    endfunction

endpackage

// File: rtl/approx_err_pipe.sv
// Two-stage exact-product / error-distance pipeline with valid bits.
// The squared error is registered alongside ed only when APPROX_ERR_SQ_EN is defined.
module approx_err_pipe
    import approx_err_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PW    = prod_w(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_fire,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [PW-1:0]   z_approx,
    output logic            s1_valid,
    output logic            s2_valid,
`ifdef APPROX_ERR_SQ_EN
    output logic [2*PW-1:0] ed_sq,
`endif
    output logic [PW-1:0]   ed
);

    logic          s1_valid_reg, s2_valid_reg;
    logic [PW-1:0] exact_reg, za_reg, ed_reg, ed_next;

    // Subtract in whichever direction keeps the result non-negative.
    assign ed_next = (exact_reg >= za_reg) ? (exact_reg - za_reg) : (za_reg - exact_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            exact_reg    <= '0;
            za_reg       <= '0;
            ed_reg       <= '0;
        end else begin
            s1_valid_reg <= in_fire;
            s2_valid_reg <= s1_valid_reg;
            if (in_fire) begin
                exact_reg <= PW'(x) * PW'(y);
                za_reg    <= z_approx;
            end
            if (s1_valid_reg)
                ed_reg <= ed_next;
        end
    end

`ifdef APPROX_ERR_SQ_EN
    logic [2*PW-1:0] ed_sq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ed_sq_reg <= '0;
        else if (s1_valid_reg)
            ed_sq_reg <= (2*PW)'(ed_next) * (2*PW)'(ed_next);
    end

    assign ed_sq = ed_sq_reg;
`endif

    assign s1_valid = s1_valid_reg;
    assign s2_valid = s2_valid_reg;
    assign ed       = ed_reg;

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error-distance statistics (sum, max, nonzero count) for approximate multipliers.
// Define APPROX_ERR_SQ_EN to also accumulate the squared error into sq_err_sum.
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int LOG2_SAMPLES = 8,
    localparam int PW           = prod_w(WIDTH),
    localparam int SW           = sum_w(WIDTH, LOG2_SAMPLES),
    localparam int CW           = cnt_w(LOG2_SAMPLES),
    localparam int QW           = sq_w(WIDTH, LOG2_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [PW-1:0]    z_approx,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    err_sum,
    output logic [PW-1:0]    err_max,
    output logic [CW-1:0]    err_cnt,
    output logic [QW-1:0]    sq_err_sum
);

    localparam int NSAMP = 2 ** LOG2_SAMPLES;

    state_t        state_reg, state_next;
    logic [CW-1:0] accepted_reg;
    logic [SW-1:0] sum_reg;
    logic [PW-1:0] max_reg;
    logic [CW-1:0] nz_cnt_reg;
    logic          accept, clear, last_sample;
    logic          s1_valid, s2_valid;
    logic [PW-1:0] ed;

    assign in_ready    = (state_reg == RUN) && (accepted_reg < CW'(NSAMP));
    assign accept      = in_valid && in_ready;
    assign last_sample = (accepted_reg == CW'(NSAMP - 1));
    assign clear       = start && ((state_reg == IDLE) || (state_reg == HOLD));

`ifdef APPROX_ERR_SQ_EN
    logic [2*PW-1:0] ed_sq;
`endif

    approx_err_pipe #(.WIDTH(WIDTH)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_fire  (accept),
        .x        (x),
        .y        (y),
        .z_approx (z_approx),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
`ifdef APPROX_ERR_SQ_EN
        .ed_sq    (ed_sq),
`endif
        .ed       (ed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, HOLD: if (start) state_next = RUN;
            RUN:        if (accept && last_sample) state_next = DRAIN;
            DRAIN:      if (!s1_valid && !s2_valid) state_next = DONE;
            DONE:       state_next = HOLD;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted_reg <= '0;
            sum_reg      <= '0;
            max_reg      <= '0;
            nz_cnt_reg   <= '0;
        end else if (clear) begin
            accepted_reg <= '0;
            sum_reg      <= '0;
            max_reg      <= '0;
            nz_cnt_reg   <= '0;
        end else begin
            if (accept)
                accepted_reg <= accepted_reg + CW'(1);
            if (s2_valid) begin
                sum_reg    <= sum_reg + SW'(ed);
                nz_cnt_reg <= nz_cnt_reg + CW'(ed != '0);
                if (ed > max_reg)
                    max_reg <= ed;
            end
        end
    end

`ifdef APPROX_ERR_SQ_EN
    logic [QW-1:0] sq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sq_reg <= '0;
        else if (clear)
            sq_reg <= '0;
        else if (s2_valid)
            sq_reg <= sq_reg + QW'(ed_sq);
    end

    assign sq_err_sum = sq_reg;
`else
    assign sq_err_sum = '0;
`endif

    assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
    assign done    = (state_reg == DONE);
    assign err_sum = sum_reg;
    assign err_max = max_reg;
    assign err_cnt = nz_cnt_reg;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with a 4-sample window.
module tb_approx_err_monitor;

    localparam int WIDTH = 8;
    localparam int L2S   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic [15:0] z_approx = '0;
    logic        busy, done;
    logic [17:0] err_sum;
    logic [15:0] err_max;
    logic [2:0]  err_cnt;
    logic [33:0] sq_err_sum;

    int checks = 0;
    int failures = 0;

    approx_err_monitor #(.WIDTH(WIDTH), .LOG2_SAMPLES(L2S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .z_approx   (z_approx),
        .busy       (busy),
        .done       (done),
        .err_sum    (err_sum),
        .err_max    (err_max),
        .err_cnt    (err_cnt),
        .sq_err_sum (sq_err_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        x = a; y = b; z_approx = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the last accept until done is seen high (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || err_sum !== 18'd0 || err_max !== 16'd0 || err_cnt !== 3'd0 || sq_err_sum !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs ready/busy/done=%b sum=%0d max=%0d cnt=%0d sq=%0d required all 0",
                     {in_ready, busy, done}, err_sum, err_max, err_cnt, sq_err_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_to_run in_ready=%b busy=%b required 1 1", in_ready, busy);
        end
        $display("reset: ready=%b busy=%b", in_ready, busy);
    endtask

    task automatic test_basic();
        int lat;
        for (int i = 0; i < 4; i++) push(8'hFF, 8'h01, 16'd254);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_entry in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL done_latency got %0d required 3", lat);
        end
        checks++;
        if (err_sum !== 18'd4 || err_max !== 16'd1 || err_cnt !== 3'd4) begin
            failures++;
            $display("FAIL basic_stats sum=%0d max=%0d cnt=%0d required 4 1 4", err_sum, err_max, err_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err_sum !== 18'd4 || err_cnt !== 3'd4) begin
            failures++;
            $display("FAIL hold_state done=%b busy=%b sum=%0d cnt=%0d required 0 0 4 4", done, busy, err_sum, err_cnt);
        end
        $display("basic: lat=%0d sum=%0d max=%0d cnt=%0d", lat, err_sum, err_max, err_cnt);
    endtask

    task automatic test_sign();
        int lat;
        pulse_start();
        push(8'd3, 8'd5, 16'd15);
        push(8'd2, 8'd7, 16'd14);
        push(8'd4, 8'd4, 16'd16);
        push(8'd0, 8'd9, 16'd0);
        wait_done(lat);
        checks++;
        if (lat >= 20 || err_sum !== 18'd0 || err_max !== 16'd0 || err_cnt !== 3'd0) begin
            failures++;
            $display("FAIL exact_window lat=%0d sum=%0d max=%0d cnt=%0d required 0 0 0", lat, err_sum, err_max, err_cnt);
        end
        $display("exact: sum=%0d max=%0d cnt=%0d", err_sum, err_max, err_cnt);
        tick();
        pulse_start();
        push(8'd3, 8'd5, 16'd17);   // over-estimate, ed=2
        push(8'd3, 8'd5, 16'd13);   // under-estimate, ed=2
        push(8'd10, 8'd10, 16'd90); // ed=10
        push(8'd1, 8'd1, 16'd1);    // exact
        wait_done(lat);
        checks++;
        if (lat >= 20 || err_sum !== 18'd14 || err_max !== 16'd10 || err_cnt !== 3'd3) begin
            failures++;
            $display("FAIL sign_window lat=%0d sum=%0d max=%0d cnt=%0d required 14 10 3", lat, err_sum, err_max, err_cnt);
        end
        $display("sign: sum=%0d max=%0d cnt=%0d", err_sum, err_max, err_cnt);
        tick();
    endtask

    task automatic test_gaps();
        logic [7:0]  xs [4] = '{8'd6, 8'd2, 8'd9, 8'd1};
        logic [7:0]  ys [4] = '{8'd6, 8'd3, 8'd9, 8'd200};
        logic [15:0] zs [4] = '{16'd30, 16'd6, 16'd100, 16'd199};
        int lat;
        int ready_bad = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            push(xs[i], ys[i], zs[i]);
            if (i < 3) begin
                // Idle cycle with a huge-error operand that must not be counted.
                x = 8'hFF; y = 8'hFF; z_approx = 16'd0;
                start = (i == 1);
                tick();
                start = 1'b0;
            end
        end
        x = 8'hFF; y = 8'hFF; z_approx = 16'd0; in_valid = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            if (in_ready !== 1'b0) ready_bad++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (ready_bad !== 0 || lat !== 3) begin
            failures++;
            $display("FAIL ready_after_full ready_high_cycles=%0d lat=%0d required 0 3", ready_bad, lat);
        end
        checks++;
        if (err_sum !== 18'd26 || err_max !== 16'd19 || err_cnt !== 3'd3) begin
            failures++;
            $display("FAIL gap_stats sum=%0d max=%0d cnt=%0d required 26 19 3", err_sum, err_max, err_cnt);
        end
        $display("gaps: sum=%0d max=%0d cnt=%0d", err_sum, err_max, err_cnt);
        tick();
    endtask

    task automatic test_abort();
        int lat;
        int done_seen = 0;
        pulse_start();
        push(8'd7, 8'd7, 16'd40);
        push(8'd7, 8'd7, 16'd40);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || err_sum !== 18'd0 || err_max !== 16'd0 || err_cnt !== 3'd0) begin
            failures++;
            $display("FAIL abort_clear ready/busy/done=%b sum=%0d max=%0d cnt=%0d required all 0",
                     {in_ready, busy, done}, err_sum, err_max, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done done_cycles=%0d busy=%b required 0 0", done_seen, busy);
        end
        pulse_start();
        for (int i = 0; i < 4; i++) push(8'd3, 8'd3, 16'd4);
        wait_done(lat);
        checks++;
        if (lat !== 3 || err_sum !== 18'd20 || err_max !== 16'd5 || err_cnt !== 3'd4) begin
            failures++;
            $display("FAIL post_abort lat=%0d sum=%0d max=%0d cnt=%0d required 3 20 5 4", lat, err_sum, err_max, err_cnt);
        end
        $display("abort: sum=%0d max=%0d cnt=%0d", err_sum, err_max, err_cnt);
        tick();
    endtask

    task automatic test_sq();
        int lat;
        logic [33:0] sq_exp;
`ifdef APPROX_ERR_SQ_EN
        sq_exp = 34'd30;
`else
        sq_exp = 34'd0;
`endif
        pulse_start();
        for (int i = 1; i <= 4; i++) push(8'd1, 8'(i), 16'd0);
        wait_done(lat);
        checks++;
        if (lat >= 20 || err_sum !== 18'd10 || err_max !== 16'd4 || err_cnt !== 3'd4) begin
            failures++;
            $display("FAIL sq_window_stats lat=%0d sum=%0d max=%0d cnt=%0d required 10 4 4", lat, err_sum, err_max, err_cnt);
        end
        checks++;
        if (sq_err_sum !== sq_exp) begin
            failures++;
            $display("FAIL sq_err_sum got %0d required %0d", sq_err_sum, sq_exp);
        end
        $display("sq: sum=%0d sq=%0d", err_sum, sq_err_sum);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_gaps();
        test_abort();
        test_sq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
